usr_seq: RTL and testbench

Parametrised universal shift register with a multi-cycle shift sequencer. It supports parallel load, clear, and logical, arithmetic and rotate shifts in both directions. A multi-position shift runs one position per clock under a Start/Busy/Done handshake. It replaces the fixed 8-bit, four-mode shift register in the datapath, and serves as the shift/rotate unit behind the ALU and the serial link front end.

---
 rtl/usr_seq_if.sv | 28 ++
 rtl/usr_seq.sv | 96 +++++++++
 tb/tb_usr_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/usr_seq_if.sv
// Start/Busy/Done command and data bus of the universal shift sequencer.
// Master drives the command and serial fill bits; slave returns register state and status.
interface usr_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             Start;
    logic [2:0]       Op;
    logic [CNT_W-1:0] Amt;
    logic [WIDTH-1:0] Datain;
    logic             SerInL;
    logic             SerInR;
    logic [WIDTH-1:0] Dataout;
    logic             SerOutL;
    logic             SerOutR;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Op, Amt, Datain, SerInL, SerInR,
        input  Dataout, SerOutL, SerOutR, Busy, Done
    );

    modport slave (
        input  Start, Op, Amt, Datain, SerInL, SerInR,
        output Dataout, SerOutL, SerOutR, Busy, Done
    );
endinterface

// File: rtl/usr_seq.sv
// Universal shift register; load/clear/nop complete in 1 cycle, an N-position shift in N+1 cycles.
// Start is ignored while Busy (no queuing); a Start in the Done cycle is accepted back-to-back.
module usr_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic     clk,
    input logic     Rst,
    usr_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_shifted;

    assign w_accept   = bus.Start && (r_state != RUN);
    assign w_is_shift = (bus.Op >= OP_SLL) && (bus.Op <= OP_SRA);

    // One position of the latched op; serial fill bits are sampled live each shift edge.
    always_comb begin
        w_shifted = r_data;
        case (r_op)
            OP_SLL:  w_shifted = {r_data[WIDTH-2:0], bus.SerInR};
            OP_SRL:  w_shifted = {bus.SerInL, r_data[WIDTH-1:1]};
            OP_ROL:  w_shifted = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            OP_ROR:  w_shifted = {r_data[0], r_data[WIDTH-1:1]};
            OP_SRA:  w_shifted = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            default: w_shifted = r_data;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_op    <= OP_NOP;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_data <= w_shifted;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    if (w_accept) begin
                        r_op <= bus.Op;
                        if (bus.Op == OP_LD)
                            r_data <= bus.Datain;
                        else if (bus.Op == OP_CLR)
                            r_data <= '0;
                        if (w_is_shift && (bus.Amt != '0)) begin
                            r_cnt   <= bus.Amt;
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.Dataout = r_data;
    assign bus.SerOutL = r_data[WIDTH-1];
    assign bus.SerOutR = r_data[0];
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq at WIDTH=8: reference model pushes expected register values per edge,
// which are popped and compared as the DUT steps through each operation.
module tb_usr_seq;
    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    usr_seq_if #(.WIDTH(8), .CNT_W(4)) bus();
    usr_seq #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .Rst(Rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_data = 8'h00;

    function automatic logic [7:0] mshift(input logic [2:0] op, input logic [7:0] d,
                                          input logic sl, input logic sr);
        case (op)
            3'd2:    return (d << 1) | {7'd0, sr};
            3'd3:    return (d >> 1) | {sl, 7'd0};
            3'd4:    return (d << 1) | (d >> 7);
            3'd5:    return (d >> 1) | (d << 7);
            3'd6:    return 8'($signed(d) >>> 1);
            default: return d;
        endcase
    endfunction

    // noisy: issue ignored load requests while the shift is running.
    // b2b: leave the Done cycle open so the next call is accepted on the edge ending Done.
    task automatic run_op(input logic [2:0] op, input int amt, input logic [7:0] din,
                          input logic sl, input logic sr, input bit noisy, input bit b2b,
                          input string name);
        logic [7:0] e;
        int n;
        n = (op >= 3'd2 && op <= 3'd6) ? amt : 0;
        if (op == 3'd1) m_data = din;
        else if (op == 3'd7) m_data = 8'h00;
        if (n == 0) exp_q.push_back(m_data);
        for (int k = 0; k < n; k++) begin
            m_data = mshift(op, m_data, sl, sr);
            exp_q.push_back(m_data);
        end
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.Amt = 4'(amt); bus.Datain = din;
        bus.SerInL = sl; bus.SerInR = sr;
        @(posedge clk); #1;
        if (n == 0) begin
            e = exp_q.pop_front();
            checks++; if (bus.Dataout !== e) begin errors++; $display("FAIL %s data got %h want %h", name, bus.Dataout, e); end
            checks++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin errors++; $display("FAIL %s 1cyc done/busy got %b/%b want 1/0", name, bus.Done, bus.Busy); end
        end else begin
            checks++; if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin errors++; $display("FAIL %s accept busy/done got %b/%b want 1/0", name, bus.Busy, bus.Done); end
        end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (noisy && i < n) begin
                bus.Start = 1'b1; bus.Op = 3'd1; bus.Datain = 8'hFF; bus.Amt = 4'd1;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (bus.Dataout !== e) begin errors++; $display("FAIL %s shift%0d data got %h want %h", name, i, bus.Dataout, e); end
            checks++; if (bus.SerOutL !== e[7] || bus.SerOutR !== e[0]) begin errors++; $display("FAIL %s shift%0d serout got %b%b want %b%b", name, i, bus.SerOutL, bus.SerOutR, e[7], e[0]); end
            checks++; if (bus.Busy !== (i < n) || bus.Done !== (i == n)) begin errors++; $display("FAIL %s shift%0d busy/done got %b/%b want %b/%b", name, i, bus.Busy, bus.Done, (i < n), (i == n)); end
        end
        if (!b2b) begin
            @(negedge clk); bus.Start = 1'b0;
            @(posedge clk); #1;
            checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL %s idle done/busy got %b/%b want 0/0", name, bus.Done, bus.Busy); end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; bus.Start = 1'b0; bus.Op = 3'd0; bus.Amt = 4'd0; bus.Datain = 8'h00;
        bus.SerInL = 1'b0; bus.SerInR = 1'b0;
        #1;
        checks++; if (bus.Dataout !== 8'h00) begin errors++; $display("FAIL reset data got %h want 00", bus.Dataout); end
        checks++; if ({bus.SerOutL, bus.SerOutR, bus.Busy, bus.Done} !== 4'b0000) begin errors++; $display("FAIL reset status got %b want 0000", {bus.SerOutL, bus.SerOutR, bus.Busy, bus.Done}); end
        repeat (2) @(posedge clk);
        @(negedge clk); Rst = 1'b0;
    endtask

    task automatic test_load();
        run_op(3'd1, 0, 8'hA5, 1'b0, 1'b0, 0, 0, "load");
        checks++; if (bus.Dataout !== 8'hA5) begin errors++; $display("FAIL load final got %h want a5", bus.Dataout); end
    endtask

    task automatic test_rol();
        run_op(3'd4, 3, 8'h00, 1'b0, 1'b0, 0, 0, "rol3");
        checks++; if (bus.Dataout !== 8'h2D) begin errors++; $display("FAIL rol3 final got %h want 2d", bus.Dataout); end
        run_op(3'd4, 8, 8'h00, 1'b0, 1'b0, 0, 0, "rol8");
        checks++; if (bus.Dataout !== 8'h2D) begin errors++; $display("FAIL rol8 final got %h want 2d", bus.Dataout); end
    endtask

    task automatic test_sra_sll();
        run_op(3'd1, 0, 8'h96, 1'b0, 1'b0, 0, 0, "load96");
        run_op(3'd6, 2, 8'h00, 1'b0, 1'b0, 0, 0, "sra2");
        checks++; if (bus.Dataout !== 8'hE5) begin errors++; $display("FAIL sra2 final got %h want e5", bus.Dataout); end
        run_op(3'd1, 0, 8'h2D, 1'b0, 1'b0, 0, 0, "load2d");
        run_op(3'd2, 4, 8'h00, 1'b0, 1'b1, 0, 0, "sll4");
        checks++; if (bus.Dataout !== 8'hDF) begin errors++; $display("FAIL sll4 final got %h want df", bus.Dataout); end
    endtask

    task automatic test_busy_ignore();
        run_op(3'd5, 3, 8'h00, 1'b0, 1'b0, 1, 0, "ror3_noisy");
        checks++; if (bus.Dataout !== 8'hFB) begin errors++; $display("FAIL ror3_noisy final got %h want fb", bus.Dataout); end
    endtask

    task automatic test_back_to_back();
        run_op(3'd5, 2, 8'h00, 1'b0, 1'b0, 0, 1, "b2b_ror2");
        run_op(3'd1, 0, 8'h3C, 1'b0, 1'b0, 0, 1, "b2b_load");
        run_op(3'd3, 1, 8'h00, 1'b1, 1'b0, 0, 1, "b2b_srl1");
        run_op(3'd7, 0, 8'h00, 1'b0, 1'b0, 0, 0, "b2b_clr");
    endtask

    task automatic test_large_amt();
        run_op(3'd1, 0, 8'h81, 1'b0, 1'b0, 0, 0, "load81");
        run_op(3'd4, 11, 8'h00, 1'b0, 1'b0, 0, 0, "rol11");
        checks++; if (bus.Dataout !== 8'h0C) begin errors++; $display("FAIL rol11 final got %h want 0c", bus.Dataout); end
        run_op(3'd2, 10, 8'h00, 1'b0, 1'b0, 0, 0, "sll10");
        run_op(3'd1, 0, 8'h80, 1'b0, 1'b0, 0, 0, "load80");
        run_op(3'd6, 12, 8'h00, 1'b0, 1'b0, 0, 0, "sra12");
        checks++; if (bus.Dataout !== 8'hFF) begin errors++; $display("FAIL sra12 final got %h want ff", bus.Dataout); end
        run_op(3'd7, 0, 8'h00, 1'b0, 1'b0, 0, 0, "clr");
        run_op(3'd3, 9, 8'h00, 1'b1, 1'b0, 0, 0, "srl9");
    endtask

    task automatic test_reset_abort();
        int dones;
        logic [7:0] e;
        run_op(3'd1, 0, 8'hB4, 1'b0, 1'b0, 0, 0, "loadb4");
        for (int k = 0; k < 2; k++) begin
            m_data = mshift(3'd3, m_data, 1'b1, 1'b0);
            exp_q.push_back(m_data);
        end
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 3'd3; bus.Amt = 4'd5; bus.SerInL = 1'b1; bus.SerInR = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); bus.Start = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (bus.Dataout !== e || bus.Busy !== 1'b1) begin errors++; $display("FAIL abort shift%0d data/busy got %h/%b want %h/1", i, bus.Dataout, bus.Busy, e); end
        end
        #1 Rst = 1'b1;
        #1;
        checks++; if (bus.Dataout !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL abort async got %h/%b/%b want 00/0/0", bus.Dataout, bus.Busy, bus.Done); end
        @(negedge clk); Rst = 1'b0;
        m_data = 8'h00;
        exp_q.delete();
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) dones++;
        end
        checks++; if (dones !== 0 || bus.Dataout !== 8'h00) begin errors++; $display("FAIL abort after got %0d done/busy cycles data %h want 0 and 00", dones, bus.Dataout); end
    endtask

    task automatic test_single_cycle();
        run_op(3'd1, 0, 8'h5A, 1'b0, 1'b0, 0, 0, "load5a");
        run_op(3'd3, 0, 8'h00, 1'b1, 1'b0, 0, 0, "srl0");
        checks++; if (bus.Dataout !== 8'h5A) begin errors++; $display("FAIL srl0 final got %h want 5a", bus.Dataout); end
        run_op(3'd0, 7, 8'hFF, 1'b0, 1'b0, 0, 0, "nop");
        run_op(3'd7, 0, 8'hFF, 1'b0, 1'b0, 0, 0, "clear");
        checks++; if (bus.Dataout !== 8'h00) begin errors++; $display("FAIL clear final got %h want 00", bus.Dataout); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_rol();
        test_sra_sll();
        test_busy_ignore();
        test_back_to_back();
        test_large_amt();
        test_reset_abort();
        test_single_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
